// File: rtl/rf_writeback_queue_if.sv
// Producer-side write-back handshake into rf_writeback_queue.
// The producer holds wb_valid/wb_reg/wb_data; the queue answers with wb_ready.
interface rf_writeback_queue_if #(
   parameter int unsigned WIDTH = 32
);
   logic             wb_valid;
   logic [4:0]       wb_reg;
   logic [WIDTH-1:0] wb_data;
   logic             wb_ready;

   modport master (output wb_valid, output wb_reg, output wb_data, input wb_ready);
   modport slave  (input wb_valid, input wb_reg, input wb_data, output wb_ready);
endinterface

// File: rtl/rf_writeback_queue.sv
// Circular write-back buffer feeding the register-file write port one entry per cycle,
// with two combinational bypass lookups over pending (queued or committing) writes.
module rf_writeback_queue #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   rf_writeback_queue_if.slave    wb,
   output logic                   o_reg_write,
   output logic [4:0]             o_write_register,
   output logic [WIDTH-1:0]       o_write_data,
   input  logic [4:0]             i_lookup_reg_1,
   input  logic [4:0]             i_lookup_reg_2,
   output logic                   o_hit_1,
   output logic                   o_hit_2,
   output logic [WIDTH-1:0]       o_hit_data_1,
   output logic [WIDTH-1:0]       o_hit_data_2,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]       r_reg_mem  [DEPTH];
   logic [WIDTH-1:0] r_data_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_reg_write;
   logic [4:0]       r_write_register;
   logic [WIDTH-1:0] r_write_data;

   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign w_full      = (r_count == CW'(DEPTH));
   assign wb.wb_ready = !w_full;
   assign w_push      = wb.wb_valid && !w_full;
   assign w_pop       = (r_count != '0);

   // Storage needs no reset: entries are only read below r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_reg_mem[r_wr_ptr]  <= wb.wb_reg;
         r_data_mem[r_wr_ptr] <= wb.wb_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         r_reg_write      <= 1'b0;
         r_write_register <= '0;
         r_write_data     <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count     <= r_count + CW'(w_push) - CW'(w_pop);
         r_reg_write <= w_pop;
         if (w_pop) begin
            r_write_register <= r_reg_mem[r_rd_ptr];
            r_write_data     <= r_data_mem[r_rd_ptr];
         end
      end
   end

   logic [1:0][4:0]       w_lookup;
   logic [1:0]            w_hit;
   logic [1:0][WIDTH-1:0] w_hit_data;
   logic [PW-1:0]         w_idx;

   assign w_lookup[0] = i_lookup_reg_1;
   assign w_lookup[1] = i_lookup_reg_2;

   // Scan oldest to youngest so later matches override: output stage first, then queue.
   always_comb begin
      w_hit      = '0;
      w_hit_data = '0;
      w_idx      = '0;
      for (int k = 0; k < 2; k++) begin
         if (r_reg_write && (r_write_register == w_lookup[k])) begin
            w_hit[k]      = 1'b1;
            w_hit_data[k] = r_write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_reg_mem[w_idx] == w_lookup[k])) begin
               w_hit[k]      = 1'b1;
               w_hit_data[k] = r_data_mem[w_idx];
            end
         end
      end
   end

   assign o_hit_1          = w_hit[0];
   assign o_hit_2          = w_hit[1];
   assign o_hit_data_1     = w_hit_data[0];
   assign o_hit_data_2     = w_hit_data[1];
   assign o_reg_write      = r_reg_write;
   assign o_write_register = r_write_register;
   assign o_write_data     = r_write_data;
   assign o_count          = r_count;
   assign o_empty          = (r_count == '0) && !r_reg_write;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue (DEPTH=2) against a queue-based reference model.
module tb_rf_writeback_queue;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rf_writeback_queue_if #(.WIDTH(WIDTH)) wb_if ();

   logic [4:0]       lk1;
   logic [4:0]       lk2;
   logic             o_reg_write;
   logic [4:0]       o_write_register;
   logic [WIDTH-1:0] o_write_data;
   logic             o_hit_1;
   logic             o_hit_2;
   logic [WIDTH-1:0] o_hit_data_1;
   logic [WIDTH-1:0] o_hit_data_2;
   logic             o_empty;
   logic [CW-1:0]    o_count;

   rf_writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .wb              (wb_if),
      .o_reg_write     (o_reg_write),
      .o_write_register(o_write_register),
      .o_write_data    (o_write_data),
      .i_lookup_reg_1  (lk1),
      .i_lookup_reg_2  (lk2),
      .o_hit_1         (o_hit_1),
      .o_hit_2         (o_hit_2),
      .o_hit_data_1    (o_hit_data_1),
      .o_hit_data_2    (o_hit_data_2),
      .o_empty         (o_empty),
      .o_count         (o_count)
   );

   typedef struct packed {
      logic [4:0]       r;
      logic [WIDTH-1:0] d;
   } ent_t;

   ent_t mq[$];           // pending entries, oldest at front
   ent_t m_out;           // committing entry (held after its pulse)
   bit   m_out_v;
   ent_t obs_commits[$];
   ent_t acc[$];
   int   total = 0;
   int   bad = 0;
   int   cmax;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Youngest pending write wins; the output stage is the oldest candidate.
   task automatic model_lookup(input logic [4:0] idx, output logic h, output logic [WIDTH-1:0] d);
      h = 1'b0;
      d = '0;
      if (m_out_v && m_out.r == idx) begin
         h = 1'b1;
         d = m_out.d;
      end
      foreach (mq[i]) begin
         if (mq[i].r == idx) begin
            h = 1'b1;
            d = mq[i].d;
         end
      end
   endtask

   task automatic check_all();
      logic             h;
      logic [WIDTH-1:0] d;
      chk("reg_write", WIDTH'(o_reg_write), WIDTH'(m_out_v));
      chk("write_register", WIDTH'(o_write_register), WIDTH'(m_out.r));
      chk("write_data", o_write_data, m_out.d);
      chk("wb_ready", WIDTH'(wb_if.wb_ready), WIDTH'(mq.size() != DEPTH));
      chk("count", WIDTH'(o_count), WIDTH'(mq.size()));
      chk("empty", WIDTH'(o_empty), WIDTH'(mq.size() == 0 && !m_out_v));
      model_lookup(lk1, h, d);
      chk("hit_1", WIDTH'(o_hit_1), WIDTH'(h));
      chk("hit_data_1", o_hit_data_1, d);
      model_lookup(lk2, h, d);
      chk("hit_2", WIDTH'(o_hit_2), WIDTH'(h));
      chk("hit_data_2", o_hit_data_2, d);
      chk("ready_vs_count", WIDTH'(wb_if.wb_ready), WIDTH'(o_count != CW'(DEPTH)));
   endtask

   task automatic model_reset();
      mq.delete();
      m_out   = '0;
      m_out_v = 1'b0;
   endtask

   // Drive one cycle of inputs, check outputs against the model, then advance one edge.
   task automatic step(input logic v, input logic [4:0] r, input logic [WIDTH-1:0] d,
                       input logic [4:0] l1, input logic [4:0] l2);
      bit acc_now;
      #1;
      wb_if.wb_valid = v;
      wb_if.wb_reg   = r;
      wb_if.wb_data  = d;
      lk1            = l1;
      lk2            = l2;
      #1;
      check_all();
      if (o_reg_write) obs_commits.push_back('{o_write_register, o_write_data});
      acc_now = v && (mq.size() != DEPTH);
      @(posedge clk);
      if (mq.size() > 0) begin
         m_out   = mq.pop_front();
         m_out_v = 1'b1;
      end else begin
         m_out_v = 1'b0;
      end
      if (acc_now) begin
         mq.push_back('{r, d});
         acc.push_back('{r, d});
      end
   endtask

   initial begin
      rst            = 1'b1;
      wb_if.wb_valid = 1'b0;
      wb_if.wb_reg   = '0;
      wb_if.wb_data  = '0;
      lk1            = '0;
      lk2            = '0;
      model_reset();

      // Reset state
      #2;
      check_all();
      @(posedge clk);
      #2 rst = 1'b0;

      // Single write: commit visible after edge 2, gone after edge 3
      step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      step(1'b0, 5'd0, '0, 5'd0, 5'd0);
      #1;
      chk("single_reg_write", WIDTH'(o_reg_write), 1);
      chk("single_write_register", WIDTH'(o_write_register), 5);
      chk("single_write_data", o_write_data, 32'hDEADBEEF);
      step(1'b0, 5'd0, '0, 5'd0, 5'd0);
      #1;
      chk("single_reg_write_off", WIDTH'(o_reg_write), 0);

      // Back-to-back pushes drain in order with count <= 1
      obs_commits.delete();
      cmax = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 5'(i + 1), WIDTH'(17 * (i + 1)), 5'd0, 5'd0);
         #1;
         if (int'(o_count) > cmax) cmax = int'(o_count);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 5'd0, '0, 5'd0, 5'd0);
      chk("b2b_count_max_le1", WIDTH'(cmax <= 1), 1);
      chk("b2b_commits", WIDTH'(obs_commits.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < obs_commits.size()) begin
            chk("b2b_reg", WIDTH'(obs_commits[i].r), WIDTH'(i + 1));
            chk("b2b_data", obs_commits[i].d, WIDTH'(17 * (i + 1)));
         end
      end

      // Bypass priority: youngest of two writes to reg 7
      step(1'b1, 5'd7, 32'hA, 5'd7, 5'd8);
      step(1'b1, 5'd7, 32'hB, 5'd7, 5'd8);
      #1;
      chk("bp_hit_1", WIDTH'(o_hit_1), 1);
      chk("bp_hit_data_1", o_hit_data_1, 32'hB);
      chk("bp_hit_2", WIDTH'(o_hit_2), 0);
      chk("bp_hit_data_2", o_hit_data_2, 0);
      step(1'b0, 5'd0, '0, 5'd7, 5'd8);
      step(1'b0, 5'd0, '0, 5'd7, 5'd8);
      #1;
      chk("bp_hit_1_after", WIDTH'(o_hit_1), 0);
      chk("bp_hit_data_1_after", o_hit_data_1, 0);

      // Output-stage bypass with empty queue
      step(1'b1, 5'd9, 32'h55, 5'd0, 5'd0);
      step(1'b0, 5'd0, '0, 5'd9, 5'd0);
      #1;
      chk("os_reg_write", WIDTH'(o_reg_write), 1);
      chk("os_count", WIDTH'(o_count), 0);
      chk("os_hit_1", WIDTH'(o_hit_1), 1);
      chk("os_hit_data_1", o_hit_data_1, 32'h55);
      step(1'b0, 5'd0, '0, 5'd0, 5'd0);

      // Asynchronous reset mid-burst discards pending writes
      step(1'b1, 5'd10, 32'h100, 5'd12, 5'd11);
      step(1'b1, 5'd11, 32'h101, 5'd12, 5'd11);
      step(1'b1, 5'd12, 32'h102, 5'd12, 5'd11);
      #3;
      wb_if.wb_valid = 1'b0;
      rst            = 1'b1;
      #1;
      model_reset();
      chk("rst_reg_write", WIDTH'(o_reg_write), 0);
      chk("rst_write_register", WIDTH'(o_write_register), 0);
      chk("rst_write_data", o_write_data, 0);
      chk("rst_count", WIDTH'(o_count), 0);
      chk("rst_empty", WIDTH'(o_empty), 1);
      chk("rst_wb_ready", WIDTH'(wb_if.wb_ready), 1);
      chk("rst_hit_1", WIDTH'(o_hit_1), 0);
      chk("rst_hit_data_1", o_hit_data_1, 0);
      chk("rst_hit_2", WIDTH'(o_hit_2), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      obs_commits.delete();
      for (int i = 0; i < 3; i++) step(1'b0, 5'd0, '0, 5'd12, 5'd11);
      chk("rst_no_commit", WIDTH'(obs_commits.size()), 0);

      // Held wb_valid over 10 pushes: pointers wrap, sequence preserved
      obs_commits.delete();
      acc.delete();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 5'($urandom_range(0, 31)), WIDTH'($urandom), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 3; i++) step(1'b0, 5'd0, '0, 5'd0, 5'd0);
      chk("wrap_commit_count", WIDTH'(obs_commits.size()), WIDTH'(acc.size()));
      for (int i = 0; i < 10; i++) begin
         if (i < obs_commits.size() && i < acc.size()) begin
            chk("wrap_reg", WIDTH'(obs_commits[i].r), WIDTH'(acc[i].r));
            chk("wrap_data", obs_commits[i].d, acc[i].d);
         end
      end

      // Random traffic over a small register set to provoke bypass hits
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), WIDTH'($urandom),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
